update_global_lvl_states: RTL
=============================

Name: update_global_lvl_states

Overview:
- Upstream neighbour of the global backtrack-level search in the bin manager.
- After a bin finishes local solving, this block records the new global decision levels in the lvl-states BRAM. Each entry written is {bin_id, has_bkt=0}.
- It then zeroes stale entries left above the new top from an earlier, deeper search.
- It owns the global top-level register that later seeds the backtrack search.

Parameters:
- WIDTH_LVL, 16, global decision level width; must be >= ADDR_WIDTH_LVLS_STATES.
- WIDTH_BIN_ID, 10, bin identifier width.
- WIDTH_LVL_STATES, 30, lvl-state word width; must be >= WIDTH_BIN_ID+1.
- ADDR_WIDTH_LVLS_STATES, 9, lvl-states BRAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start_update  in  1  single-cycle request; sampled only in IDLE.
- bin_id_i  in  WIDTH_BIN_ID  bin that produced the levels.
- base_lvl_i  in  WIDTH_LVL  global level at which the bin started.
- local_lvl_cnt_i  in  WIDTH_LVL  number of new levels produced by the bin.
- apply_update_o  out  1  high while the block owns the BRAM port (drives the mux).
- done_update  out  1  one-cycle completion pulse.
- overflow_o  out  1  one-cycle pulse, coincident with done_update, when the level range was saturated.
- top_lvl_o  out  WIDTH_LVL  current global top level.
- ram_we_l_state_o  out  1  BRAM write enable.
- ram_data_l_state_o  out  WIDTH_LVL_STATES  write data.
- ram_addr_l_state_o  out  ADDR_WIDTH_LVLS_STATES  BRAM address.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - All outputs = 0, including top_lvl_o.
  - Internal latches and counters = 0.
- Data format: ram_data_l_state_o = {zero pad, bin_id, has_bkt}, with has_bkt in bit 0.
  - New levels are written as {bin_id_r, 1'b0}.
  - Clear writes are all-zero words.
- In IDLE, start_update latches the following, and the block goes to WRITE_NEW:
  - bin_id_r.
  - new_top = base_lvl_i + local_lvl_cnt_i, computed at WIDTH_LVL+1 bits.
  - old_top = top_lvl_o.
  - wr_lvl = base_lvl_i + 1.
- Saturation: if new_top > 2^ADDR_WIDTH_LVLS_STATES - 1, new_top is clamped to that value and an overflow flag is set. The flag is emitted as overflow_o together with done_update.
- start_update outside IDLE is ignored (not queued).
- Level 0 is reserved and never written. base_lvl_i = 0 is legal, and the first write then goes to address 1.
- FSM states and transitions:
  - IDLE -> WRITE_NEW on start_update.
  - WRITE_NEW: one write per cycle at address wr_lvl, then wr_lvl++.
    - Leaves after writing new_top.
    - With local_lvl_cnt_i = 0 it performs no writes and exits after one cycle.
    - Goes to CLEAR_STALE if old_top > new_top, otherwise to DONE.
  - CLEAR_STALE: writes zero to addresses new_top+1 .. old_top, one per cycle, in ascending order, then goes to DONE.
  - DONE: top_lvl_o <= new_top; done_update = 1 for one cycle; then IDLE.
- Outputs are registered.
  - Write strobes appear the cycle after the state/counter that produced them.
  - Strobes are contiguous from cycle start+2.
  - ram_we_l_state_o = 0 and address = 0 whenever no write is issued.
- Latency: done_update is asserted exactly 2 + n_write + n_clear cycles after the start cycle. Thus cnt=0 with no clear gives done at start+2.
- apply_update_o is high from the cycle after start through the cycle done_update is high, and low otherwise.
- top_lvl_o changes only in DONE, so downstream blocks see a stable top during the update.
- Address arithmetic uses the low ADDR_WIDTH_LVLS_STATES bits after saturation; no wrap-around is possible.
- Reset asserted mid-operation:
  - Aborts immediately and returns the block to IDLE with all outputs 0.
  - The BRAM may be left partially written; the controller re-initialises it.

Decomposition:
- Shared bin-manager package holds:
  - The lvl-state field layout: bin_id position and has_bkt bit index.
  - The reserved level-0 constant.
  - A MAX_LVL constant derived from ADDR_WIDTH_LVLS_STATES.
- The same package is used by the backtrack-level search.
- Optional sub-module lvl_range_writer: a start/end address walker with a data word and done. It is instantiated twice, or time-shared across WRITE_NEW and CLEAR_STALE.

Test Plan:
- Reset, then start with base=0, cnt=3, bin=5:
  - Writes addr 1,2,3 with data {5,0} (0x00A) on cycles start+2..start+4.
  - done_update at start+5; top_lvl_o=3.
- From top=3, start with base=1, cnt=0, bin=7:
  - No new writes; clears addr 2,3 to 0.
  - done_update at start+4; top_lvl_o=1.
- From top=1, start with base=1, cnt=4, bin=2:
  - Writes addr 2..5 with {2,0}; no clear.
  - done at start+6; top=5.
- base=510, cnt=5 (ADDR 9):
  - Writes addr 511 only.
  - done at start+3; overflow_o=1 on that cycle; top=511.
- start_update re-pulsed during WRITE_NEW:
  - Ignored; write count and done timing unchanged.
- rst pulsed low mid-WRITE_NEW:
  - Outputs 0 asynchronously; state IDLE; top_lvl_o=0.
  - Next start proceeds normally.

Source files
------------

// File: rtl/update_global_lvl_states_pkg.sv
`default_nettype none
// ============================================================================
// Module      : update_global_lvl_states_pkg
// Description : Shared bin-manager definitions: lvl-state field layout,
//               reserved level, level-range limit and update FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package update_global_lvl_states_pkg;

    // lvl-state word layout: {zero pad, bin_id, has_bkt}
    localparam int unsigned LVL_STATE_HAS_BKT_BIT = 0;
    localparam int unsigned LVL_STATE_BIN_ID_LSB  = 1;

    // Level 0 is the root and is never recorded in the lvl-states BRAM.
    localparam int unsigned RESERVED_LVL = 0;

    localparam int unsigned LVLS_ADDR_WIDTH_DEF = 9;

    function automatic int unsigned lvl_max(input int unsigned addr_width);
        return (32'd1 << addr_width) - 32'd1;
    endfunction

    localparam int unsigned MAX_LVL = lvl_max(LVLS_ADDR_WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITE_NEW   = 2'd1,
        ST_CLEAR_STALE = 2'd2,
        ST_DONE        = 2'd3
    } lvl_upd_state_e;

endpackage
`default_nettype wire

// File: rtl/update_global_lvl_states.sv
`default_nettype none
// ============================================================================
// Module      : update_global_lvl_states
// Description : Records a finished bin's new global decision levels in the
//               lvl-states BRAM, clears stale levels above the new top and
//               owns the global top-level register.
// Revision    : 1.0 - initial release
// ============================================================================
module update_global_lvl_states
    import update_global_lvl_states_pkg::*;
#(
    parameter int unsigned WIDTH_LVL              = 16,
    parameter int unsigned WIDTH_BIN_ID           = 10,
    parameter int unsigned WIDTH_LVL_STATES       = 30,
    parameter int unsigned ADDR_WIDTH_LVLS_STATES = 9
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_update,
    input  logic [WIDTH_BIN_ID-1:0]           bin_id_i,
    input  logic [WIDTH_LVL-1:0]              base_lvl_i,
    input  logic [WIDTH_LVL-1:0]              local_lvl_cnt_i,
    output logic                              apply_update_o,
    output logic                              done_update,
    output logic                              overflow_o,
    output logic [WIDTH_LVL-1:0]              top_lvl_o,
    output logic                              ram_we_l_state_o,
    output logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_l_state_o
);

    localparam logic [WIDTH_LVL:0] c_max_lvl = (WIDTH_LVL+1)'(lvl_max(ADDR_WIDTH_LVLS_STATES));
    localparam logic [WIDTH_LVL:0] c_one     = {{WIDTH_LVL{1'b0}}, 1'b1};

    lvl_upd_state_e                    r_state;
    lvl_upd_state_e                    w_state_nxt;
    logic [WIDTH_LVL:0]                r_ptr;
    logic [WIDTH_LVL:0]                w_ptr_nxt;
    logic [WIDTH_BIN_ID-1:0]           r_bin_id;
    logic [WIDTH_LVL:0]                r_new_top;
    logic [WIDTH_LVL:0]                r_old_top;
    logic                              r_ovf;

    logic                              r_apply;
    logic                              r_done;
    logic                              r_ovf_o;
    logic [WIDTH_LVL-1:0]              r_top;
    logic                              r_we;
    logic [WIDTH_LVL_STATES-1:0]       r_data;
    logic [ADDR_WIDTH_LVLS_STATES-1:0] r_addr;

    logic [WIDTH_LVL:0]                w_sum;
    logic                              w_sat;
    logic [WIDTH_LVL:0]                w_new_top_in;
    logic                              w_clear_needed;
    logic [WIDTH_LVL:0]                w_clr_first;
    logic                              w_start;
    logic                              w_we;
    logic                              w_clr;
    logic                              w_done;
    logic [ADDR_WIDTH_LVLS_STATES-1:0] w_addr;
    logic [WIDTH_LVL_STATES-1:0]       w_data;

    assign w_start        = (r_state == ST_IDLE) && start_update;
    assign w_sum          = {1'b0, base_lvl_i} + {1'b0, local_lvl_cnt_i};
    assign w_sat          = (w_sum > c_max_lvl);
    assign w_new_top_in   = w_sat ? c_max_lvl : w_sum;
    assign w_clear_needed = (r_old_top > r_new_top);
    assign w_clr_first    = r_new_top + c_one;

    // An empty new-level range falls straight through to the first clear (or
    // to completion) in the same cycle so the strobes stay contiguous.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_we        = 1'b0;
        w_clr       = 1'b0;
        w_done      = 1'b0;
        w_addr      = '0;
        case (r_state)
            ST_IDLE: begin
                if (start_update) begin
                    w_state_nxt = ST_WRITE_NEW;
                    w_ptr_nxt   = {1'b0, base_lvl_i} + c_one;
                end
            end
            ST_WRITE_NEW: begin
                if (r_ptr <= r_new_top) begin
                    w_we   = 1'b1;
                    w_addr = r_ptr[ADDR_WIDTH_LVLS_STATES-1:0];
                    if (r_ptr == r_new_top) begin
                        if (w_clear_needed) begin
                            w_state_nxt = ST_CLEAR_STALE;
                            w_ptr_nxt   = w_clr_first;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_ptr_nxt = r_ptr + c_one;
                    end
                end else if (w_clear_needed) begin
                    w_we   = 1'b1;
                    w_clr  = 1'b1;
                    w_addr = w_clr_first[ADDR_WIDTH_LVLS_STATES-1:0];
                    if (w_clr_first == r_old_top) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_CLEAR_STALE;
                        w_ptr_nxt   = w_clr_first + c_one;
                    end
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR_STALE: begin
                w_we   = 1'b1;
                w_clr  = 1'b1;
                w_addr = r_ptr[ADDR_WIDTH_LVLS_STATES-1:0];
                if (r_ptr == r_old_top) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_ptr_nxt = r_ptr + c_one;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // has_bkt stays 0 for freshly recorded levels; clears are all-zero words.
    always_comb begin
        w_data = '0;
        if (w_we && !w_clr) begin
            w_data[LVL_STATE_BIN_ID_LSB +: WIDTH_BIN_ID] = r_bin_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin_id  <= '0;
            r_new_top <= '0;
            r_old_top <= '0;
            r_ovf     <= 1'b0;
        end else if (w_start) begin
            r_bin_id  <= bin_id_i;
            r_new_top <= w_new_top_in;
            r_old_top <= {1'b0, r_top};
            r_ovf     <= w_sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_apply <= 1'b0;
            r_done  <= 1'b0;
            r_ovf_o <= 1'b0;
            r_top   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_apply <= (w_state_nxt != ST_IDLE) || w_done;
            r_done  <= w_done;
            r_ovf_o <= w_done && r_ovf;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_data  <= w_data;
            if (w_done) begin
                r_top <= r_new_top[WIDTH_LVL-1:0];
            end
        end
    end

    assign apply_update_o     = r_apply;
    assign done_update        = r_done;
    assign overflow_o         = r_ovf_o;
    assign top_lvl_o          = r_top;
    assign ram_we_l_state_o   = r_we;
    assign ram_addr_l_state_o = r_addr;
    assign ram_data_l_state_o = r_data;

endmodule
`default_nettype wire
